// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: IF and MEM requester handshakes plus the RAM side.
// slave = arbiter view; master = requesters and RAM.
interface mem_arbiter_if #(parameter int CNT_W = 32);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_ack_o;
  logic [31:0]       if_rdata_o;
  logic              if_stall_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_ack_o;
  logic [31:0]       mem_rdata_o;
  logic              mem_stall_o;
  logic              ram_ce_o;
  logic              ram_we_o;
  logic [31:0]       ram_addr_o;
  logic [3:0]        ram_sel_o;
  logic [31:0]       ram_wdata_o;
  logic [CNT_W-1:0]  ram_cnt_o;
  logic              ram_hit_i;
  logic [31:0]       ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
           ram_hit_i, ram_rdata_i,
    output if_ack_o, if_rdata_o, if_stall_o, mem_ack_o, mem_rdata_o, mem_stall_o,
           ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o, ram_cnt_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
           ram_hit_i, ram_rdata_i,
    input  if_ack_o, if_rdata_o, if_stall_o, mem_ack_o, mem_rdata_o, mem_stall_o,
           ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o, ram_cnt_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between IF (read-only) and MEM (load/store) and drives the
// RAM latency counter. MEM_ARB_RR_EN selects round-robin on contention; default is MEM-first.
module mem_arbiter #(
  parameter int LATENCY = 200,
  parameter int CNT_W   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD      = 3'd1;
  localparam logic [2:0] RD_CHK  = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] WR_DONE = 3'd4;

  localparam logic             OWN_IF  = 1'b0;
  localparam logic             OWN_MEM = 1'b1;
  localparam logic [CNT_W-1:0] LAT     = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             run_q;
  logic [31:0]      addr_q, wdata_q, if_rdata_q, mem_rdata_q;
  logic [3:0]       sel_q;
  logic             grant_mem, rd_hit, if_ack, mem_rd_ack, mem_ack;

`ifdef MEM_ARB_RR_EN
  logic last_grant;
  assign grant_mem = bus.mem_req_i & (~bus.if_req_i | (last_grant == OWN_IF));
`else
  assign grant_mem = bus.mem_req_i;
`endif

  assign rd_hit     = (state == RD_CHK) & bus.ram_hit_i;
  assign if_ack     = rd_hit & (owner == OWN_IF);
  assign mem_rd_ack = rd_hit & (owner == OWN_MEM);
  assign mem_ack    = mem_rd_ack | (state == WR_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= OWN_IF;
      run_q       <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant  <= OWN_IF;
`endif
    end else begin
      run_q <= 1'b1;
      if (if_ack)     if_rdata_q  <= bus.ram_rdata_i;
      if (mem_rd_ack) mem_rdata_q <= bus.ram_rdata_i;
      case (state)
        IDLE: if (bus.if_req_i | bus.mem_req_i) begin
          owner   <= grant_mem ? OWN_MEM : OWN_IF;
          addr_q  <= grant_mem ? bus.mem_addr_i : bus.if_addr_i;
          sel_q   <= grant_mem ? bus.mem_sel_i : 4'hF;
          wdata_q <= grant_mem ? bus.mem_wdata_i : 32'h0;
          cnt     <= '0;
          state   <= (grant_mem & bus.mem_we_i) ? WR : RD;
`ifdef MEM_ARB_RR_EN
          last_grant <= grant_mem ? OWN_MEM : OWN_IF;
`endif
        end
        RD: state <= RD_CHK;
        RD_CHK: begin
          if (bus.ram_hit_i) begin
            state <= IDLE;
          end else begin
            // A miss at LATENCY is retried too: the RAM refills at that point.
            if (cnt < LAT) cnt <= cnt + ONE;
            state <= RD;
          end
        end
        WR: begin
          if (cnt == LAT) state <= WR_DONE;
          else            cnt   <= cnt + ONE;
        end
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // run_q keeps the stalls low while reset is held, so every output reads 0 in reset.
  assign bus.if_ack_o    = if_ack;
  assign bus.if_rdata_o  = if_ack ? bus.ram_rdata_i : if_rdata_q;
  assign bus.if_stall_o  = run_q & bus.if_req_i & ~if_ack;
  assign bus.mem_ack_o   = mem_ack;
  assign bus.mem_rdata_o = mem_rd_ack ? bus.ram_rdata_i : mem_rdata_q;
  assign bus.mem_stall_o = run_q & bus.mem_req_i & ~mem_ack;

  assign bus.ram_ce_o    = (state == RD) | (state == RD_CHK) | (state == WR);
  assign bus.ram_we_o    = (state == WR);
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_sel_o   = sel_q;
  assign bus.ram_wdata_o = wdata_q;
  assign bus.ram_cnt_o   = cnt;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported data RAM/cache block between the instruction-fetch requester and the load/store requester, and generates that block's miss-latency counter. It sits between the pipeline's IF and MEM stages and the RAM. Each cycle it either holds the RAM idle or sequences one granted access to completion: read hit/miss retry, or a write held until the latency counter reaches `LATENCY`. Requesters see a level request and a one-cycle acknowledge; the pipeline stalls on `*_stall_o`.

## Interface
- `LATENCY`, 200, cycles a RAM write or read-miss must be held before the RAM commits or refills; it is the value the RAM compares against.
- `CNT_W`, 32, width of the latency counter, equal to the register-bus width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req_i`  in  1  instruction read request; held until `if_ack_o`.
- `if_addr_i`  in  32  instruction word address.
- `if_ack_o`  out  1  one-cycle pulse; `if_rdata_o` valid in the same cycle.
- `if_rdata_o`  out  32  read data; holds its value until the next acknowledge.
- `if_stall_o`  out  1  high while `if_req_i` is high and no acknowledge is given this cycle.
- `mem_req_i`, `mem_we_i`, `mem_addr_i[31:0]`, `mem_sel_i[3:0]`, `mem_wdata_i[31:0]`  in  load/store request; held stable until `mem_ack_o`.
- `mem_ack_o`  out  1; `mem_rdata_o`  out  32; `mem_stall_o`  out  1  same rules as the IF port.
- `ram_ce_o`, `ram_we_o`  out  1  RAM chip enable and write enable.
- `ram_addr_o`  out  32; `ram_sel_o`  out  4; `ram_wdata_o`  out  32  latched request fields.
- `ram_cnt_o`  out  CNT_W  latency counter.
- `ram_hit_i`  in  1  RAM hit flag, registered by the RAM.
- `ram_rdata_i`  in  32  RAM read data, registered by the RAM.

## Operation
- States: IDLE, RD, RD_CHK, WR, WR_DONE.
- Reset value of all outputs is 0. State resets to IDLE, the counter to 0, and `last_grant` to IF.
- IDLE:
  - With no request, `ram_ce_o`=0.
  - With one request, grant it.
  - With both requests, grant per the arbitration policy (see Configuration).
  - On grant, latch addr/we/sel/wdata and the owner, clear the counter, and go to RD (read) or WR (write).
- RD: drive `ram_ce_o`=1, `ram_we_o`=0, `ram_cnt_o`=counter, then go to RD_CHK.
- RD_CHK:
  - Keep driving the RAM and sample `ram_hit_i`/`ram_rdata_i`.
  - On hit: pulse the owner's ack with the data, then go to IDLE.
  - On miss: counter = min(counter+1, LATENCY), then go to RD.
  - A miss at counter == LATENCY is also retried; the RAM refills on that edge and hits on the next check.
- WR:
  - Drive `ram_ce_o`=1, `ram_we_o`=1 with the latched fields.
  - Increment the counter each cycle.
  - When the counter == LATENCY, the RAM commits on that edge; go to WR_DONE.
- WR_DONE: `ram_ce_o`=0; pulse `mem_ack_o`; go to IDLE. IF never issues writes. A write request on the IF port cannot occur; IF is read-only.
- Counter arithmetic: unsigned, CNT_W bits, saturates at LATENCY, never wraps.
- A request dropped mid-access is protocol violation. The access still completes, and its ack is still pulsed.
- A new request arriving during an access waits. Its stall stays high.
- An async reset mid-access aborts it, and no ack is issued.

## Timing
- Read hit latency: grant edge, then RD cycle, then RD_CHK, with ack on the 3rd cycle after the request is first sampled in IDLE.
- Read miss: adds 2 cycles per retry until the RAM's hit. The worst case is about 2·LATENCY+3 cycles.
- Write: ack occurs LATENCY+2 cycles after grant.
- Back-to-back: IDLE is re-entered on the ack cycle. The next grant occurs on the following edge, giving a minimum 1-cycle bubble.
- Ack and stall are combinational from state. `stall_o` = `req_i` & ~`ack_o`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On contention, the requester not in `last_grant` wins, and `last_grant` updates on every grant.
- Not defined: fixed priority, with MEM always winning over IF on contention. `last_grant` is unused.

## Test plan
- Reset with both requests high, `rst_n` released:
  - All outputs are 0 during reset.
  - The first grant goes to MEM in both modes, because `last_grant` resets to IF.
- IF read of addr 0x04 with RAM hit: `if_ack_o` fires in cycle 3 with `if_rdata_o` = RAM word; `ram_we_o` stays 0 throughout.
- MEM write of 0xDEADBEEF to 0x100, sel 4'hF, LATENCY=200:
  - `ram_we_o` is high for exactly 201 edges.
  - `ram_cnt_o` reaches 200.
  - `mem_ack_o` fires once.
  - A later read of 0x100 returns 0xDEADBEEF.
- MEM read miss on 0x104 (RAM tag mismatch): counter climbs 0→200 with no ack; ack comes after the RAM's hit, with the correct data.
- Both requests held continuously:
  - With the macro: grants alternate MEM, IF, MEM, ….
  - Without it: IF is starved until MEM drops; `if_stall_o` stays 1 throughout.
- `rst_n` asserted at counter=100 in WR: outputs clear immediately, no ack is issued, and the write is not committed.
